// File: rtl/pending_sched.sv
// Sticky request collector feeding a highest-index priority encoder, with a
// registered valid/ready grant output. Optional sticky overflow flag: PENDING_SCHED_OVERFLOW_EN.

// Combinational highest-set-bit encoder.
module priority_enc #(
  parameter int unsigned VECTOR_W   = 8,
  parameter int unsigned POSITION_W = $clog2(VECTOR_W)
) (
  input  logic [VECTOR_W-1:0]   vector,
  output logic [POSITION_W-1:0] position,
  output logic                  valid
);

  // Ascending scan, last hit wins, so the most significant set bit is kept.
  always_comb begin
    position = '0;
    for (int unsigned i = 0; i < VECTOR_W; i++) begin
      if (vector[i]) position = POSITION_W'(i);
    end
  end

  assign valid = |vector;

endmodule

module pending_sched #(
  parameter int unsigned VECTOR_W   = 8,
  parameter int unsigned POSITION_W = $clog2(VECTOR_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VECTOR_W-1:0]   req,
  output logic                  grant_valid,
  input  logic                  grant_ready,
  output logic [POSITION_W-1:0] grant_position,
  output logic [VECTOR_W-1:0]   pending
`ifdef PENDING_SCHED_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  logic [POSITION_W-1:0] sel;
  logic                  any_pending;
  logic                  load;
  logic [VECTOR_W-1:0]   sel_onehot;
  logic [VECTOR_W-1:0]   clear_mask;
  logic [VECTOR_W-1:0]   pending_next;

  priority_enc #(
    .VECTOR_W   (VECTOR_W),
    .POSITION_W (POSITION_W)
  ) u_enc (
    .vector   (pending),
    .position (sel),
    .valid    (any_pending)
  );

  // Output register takes a new grant when empty or being drained this cycle.
  assign load         = (~grant_valid | grant_ready) & any_pending;
  assign sel_onehot   = VECTOR_W'(1) << sel;
  assign clear_mask   = load ? sel_onehot : '0;
  // New requests are OR'd in after the clear, so set wins over clear.
  assign pending_next = (pending & ~clear_mask) | req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= '0;
      grant_valid    <= 1'b0;
      grant_position <= '0;
    end else begin
      pending <= pending_next;
      if (load) begin
        grant_valid    <= 1'b1;
        grant_position <= sel;
      end else if (grant_ready) begin
        grant_valid    <= 1'b0;
      end
    end
  end

`ifdef PENDING_SCHED_OVERFLOW_EN
  logic merge_loss;

  // A request landing on a bit that is pending and not being granted is lost.
  assign merge_loss = |(req & pending & ~clear_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (merge_loss) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pending_sched.sv
// Bench for pending_sched: directed scenarios plus randomized traffic against
// a behavioural model of the pending set and the grant holder.
module tb_pending_sched;

  localparam int unsigned VW = 8;
  localparam int unsigned PW = 3;

  logic          clk;
  logic          rst;
  logic [VW-1:0] req;
  logic          grant_valid;
  logic          grant_ready;
  logic [PW-1:0] grant_position;
  logic [VW-1:0] pending;
`ifdef PENDING_SCHED_OVERFLOW_EN
  logic          overflow;
`endif

  int tests_run;
  int tests_failed;

  pending_sched #(.VECTOR_W(VW), .POSITION_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .grant_valid    (grant_valid),
    .grant_ready    (grant_ready),
    .grant_position (grant_position),
    .pending        (pending)
`ifdef PENDING_SCHED_OVERFLOW_EN
    ,
    .overflow       (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs then change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    grant_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; grant_ready = 1'b0;
    step();
    rst = 1'b0;
    req = 8'hA5;
    step();
    req = 8'h00;
    step();
    #2;
    rst = 1'b1;
    req = 8'hFF;
    #1;
    tests_run++;
    if (pending !== 8'h00) begin
      tests_failed++; $display("FAIL reset_pending got %h want 00", pending);
    end
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %b want 0", grant_valid);
    end
    tests_run++;
    if (grant_position !== 3'd0) begin
      tests_failed++; $display("FAIL reset_position got %0d want 0", grant_position);
    end
`ifdef PENDING_SCHED_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow);
    end
`endif
    step();
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    grant_ready = 1'b1;
    req = 8'b0010_0100;
    step();
    req = '0;
    tests_run++;
    if (pending !== 8'h24 || grant_valid !== 1'b0) begin
      tests_failed++; $display("FAIL prio_capture pending %h valid %b want 24 0", pending, grant_valid);
    end
    step();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd5 || pending !== 8'h04) begin
      tests_failed++;
      $display("FAIL prio_first valid %b pos %0d pending %h want 1 5 04", grant_valid, grant_position, pending);
    end
    step();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd2 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL prio_second valid %b pos %0d pending %h want 1 2 00", grant_valid, grant_position, pending);
    end
    step();
    tests_run++;
    if (grant_valid !== 1'b0 || grant_position !== 3'd2) begin
      tests_failed++; $display("FAIL prio_drain valid %b pos %0d want 0 2", grant_valid, grant_position);
    end
  endtask

  task automatic test_backpressure();
    int exp_pos[3];
    exp_pos = '{5, 7, 2};
    apply_reset();
    req = 8'h24;
    step();
    req = '0;
    step();
    req = 8'h80;
    step();
    req = '0;
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd5 || pending !== 8'h84) begin
      tests_failed++;
      $display("FAIL bp_hold valid %b pos %0d pending %h want 1 5 84", grant_valid, grant_position, pending);
    end
    step();
    tests_run++;
    if (grant_position !== 3'd5 || grant_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_stable pos %0d valid %b want 5 1", grant_position, grant_valid);
    end
    grant_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step();
      tests_run++;
      if (grant_valid !== 1'b1 || int'(grant_position) != exp_pos[i]) begin
        tests_failed++;
        $display("FAIL bp_order%0d valid %b pos %0d want 1 %0d", i, grant_valid, grant_position, exp_pos[i]);
      end
    end
    step();
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drain valid %b want 0", grant_valid);
    end
  endtask

  task automatic test_rerequest();
    apply_reset();
    req = 8'h08;
    step();
    req = '0;
    step();
    req = 8'h08;
    step();
    req = '0;
    tests_run++;
    if (pending !== 8'h08 || grant_position !== 3'd3 || grant_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rereq_pending pending %h pos %0d valid %b want 08 3 1", pending, grant_position, grant_valid);
    end
    grant_ready = 1'b1;
    step();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd3 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL rereq_regrant valid %b pos %0d pending %h want 1 3 00", grant_valid, grant_position, pending);
    end
    step();
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rereq_drain valid %b want 0", grant_valid);
    end
  endtask

  task automatic test_set_beats_clear();
    apply_reset();
    grant_ready = 1'b1;
    req = 8'h10;
    step();
    step();
    req = '0;
    tests_run++;
    if (pending !== 8'h10 || grant_valid !== 1'b1 || grant_position !== 3'd4) begin
      tests_failed++;
      $display("FAIL sbc_keep pending %h valid %b pos %0d want 10 1 4", pending, grant_valid, grant_position);
    end
`ifdef PENDING_SCHED_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL sbc_overflow got %b want 0", overflow);
    end
`endif
    step();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd4 || pending !== 8'h00) begin
      tests_failed++;
      $display("FAIL sbc_regrant valid %b pos %0d pending %h want 1 4 00", grant_valid, grant_position, pending);
    end
    step();
  endtask

  task automatic test_overflow();
    apply_reset();
    req = 8'h40;
    step();
    req = '0;
    step();
    req = 8'h01;
    step();
`ifdef PENDING_SCHED_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_first got %b want 0", overflow);
    end
`endif
    step();
    req = '0;
`ifdef PENDING_SCHED_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_second got %b want 1", overflow);
    end
`endif
    tests_run++;
    if (grant_position !== 3'd6 || pending !== 8'h01) begin
      tests_failed++; $display("FAIL ovf_hold pos %0d pending %h want 6 01", grant_position, pending);
    end
    grant_ready = 1'b1;
    step();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_position !== 3'd0) begin
      tests_failed++; $display("FAIL ovf_next valid %b pos %0d want 1 0", grant_valid, grant_position);
    end
    step();
`ifdef PENDING_SCHED_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
    apply_reset();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_cleared got %b want 0", overflow);
    end
`endif
  endtask

  // Model: a set of pending sources and one grant slot; the slot refills from
  // the highest pending source whenever it is empty or its grant is taken.
  task automatic test_random();
    bit          m_pend[VW];
    bit          m_valid;
    int          m_pos;
    bit          m_ovf;
    int          top;
    bit          take;
    logic [VW-1:0] exp_pend;
    apply_reset();
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_valid = 1'b0;
    m_pos = 0;
    m_ovf = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req = ($urandom_range(0, 2) == 0) ? VW'($urandom) : '0;
      grant_ready = 1'($urandom_range(0, 1));
      top = -1;
      for (int k = 0; k < int'(VW); k++) if (m_pend[k]) top = k;
      take = (top >= 0) && (!m_valid || grant_ready);
      for (int k = 0; k < int'(VW); k++) begin
        if (req[k] && m_pend[k] && !(take && k == top)) m_ovf = 1'b1;
      end
      if (take) begin
        m_pend[top] = 1'b0;
        m_valid = 1'b1;
        m_pos = top;
      end else if (grant_ready) begin
        m_valid = 1'b0;
      end
      for (int k = 0; k < int'(VW); k++) if (req[k]) m_pend[k] = 1'b1;
      step();
      for (int k = 0; k < int'(VW); k++) exp_pend[k] = m_pend[k];
      tests_run++;
      if (grant_valid !== m_valid || pending !== exp_pend || int'(grant_position) != m_pos) begin
        tests_failed++;
        $display("FAIL rand_cyc%0d valid %b pos %0d pending %h want %b %0d %h",
                 cyc, grant_valid, grant_position, pending, m_valid, m_pos, exp_pend);
      end
`ifdef PENDING_SCHED_OVERFLOW_EN
      tests_run++;
      if (overflow !== m_ovf) begin
        tests_failed++; $display("FAIL rand_ovf_cyc%0d got %b want %b", cyc, overflow, m_ovf);
      end
`endif
    end
    req = '0;
    grant_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    req = '0;
    grant_ready = 1'b0;
    test_reset();
    test_priority();
    test_backpressure();
    test_rerequest();
    test_set_beats_clear();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
